// File: rtl/char_controller_pkg.sv
// Shared definitions for the character controller and the fight controller:
// state codes, frame_state codes, attack phase lengths and small arithmetic helpers.
package char_controller_pkg;

  typedef enum logic [3:0] {
    ST_IDLE         = 4'd0,
    ST_LEFT         = 4'd1,
    ST_RIGHT        = 4'd2,
    ST_ATK_START    = 4'd3,
    ST_ATK_ACTIVE   = 4'd4,
    ST_ATK_RECOVERY = 4'd5,
    ST_DIR_START    = 4'd6,
    ST_DIR_ACTIVE   = 4'd7,
    ST_DIR_RECOVERY = 4'd8,
    ST_STUN         = 4'd9
  } char_state_e;

  typedef enum logic [1:0] {
    FS_NOHIT     = 2'd0,
    FS_HITSTUN   = 2'd1,
    FS_BLOCKSTUN = 2'd2
  } frame_state_e;

  localparam logic [4:0] ATK_START_LEN    = 5'd5;
  localparam logic [4:0] ATK_ACTIVE_LEN   = 5'd2;
  localparam logic [4:0] ATK_RECOVERY_LEN = 5'd16;
  localparam logic [4:0] DIR_START_LEN    = 5'd4;
  localparam logic [4:0] DIR_ACTIVE_LEN   = 5'd3;
  localparam logic [4:0] DIR_RECOVERY_LEN = 5'd15;
  localparam logic [4:0] STUN_MIN_LEN     = 5'd2;
  localparam logic [4:0] FC_MAX           = 5'd31;
  localparam logic [15:0] LFSR_SEED       = 16'hACE1;

  function automatic logic [4:0] sat_inc(input logic [4:0] v);
    return (v == FC_MAX) ? v : v + 5'd1;
  endfunction

  function automatic logic phase_done(input logic [4:0] fc, input logic [4:0] len);
    return fc == (len - 5'd1);
  endfunction

  function automatic logic [4:0] stun_len_of(input logic [4:0] load);
    return (load < STUN_MIN_LEN) ? STUN_MIN_LEN : load;
  endfunction

  function automatic logic [10:0] abs_diff(input logic [10:0] a, input logic [10:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/char_controller_cpu_lfsr.sv
// 16-bit Fibonacci LFSR driving CPU-controlled buttons; only built with CHAR_CPU_EN.
`ifdef CHAR_CPU_EN
module char_cpu_lfsr
  import char_controller_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  output logic [15:0] lfsr
);

  logic [15:0] lfsr_q, lfsr_d;
  logic        fb_s;

  // taps 16,14,13,11 of the register, shifted in at bit 0
  always_comb begin
    fb_s = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    if (step) begin
      lfsr_d = {lfsr_q[14:0], fb_s};
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr = lfsr_q;

endmodule
`endif

// File: rtl/char_controller.sv
// Per-character action state machine advancing one game frame per frame_en.
// Optional CPU-driven buttons are enabled with the CHAR_CPU_EN macro.
module char_controller
  import char_controller_pkg::*;
#(
  parameter bit         IS_P2      = 1'b0,
  parameter logic [9:0] X_START    = 10'd100,
  parameter logic [9:0] Y_BASE     = 10'd300,
  parameter logic [9:0] X_MIN      = 10'd0,
  parameter logic [9:0] X_MAX      = 10'd576,
  parameter logic [9:0] CHAR_W     = 10'd64,
  parameter int         FWD_SPEED  = 3,
  parameter int         BACK_SPEED = 2
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_en,
  input  logic       input_active,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_attack,
  input  logic       cpu_mode,
  input  logic [9:0] opp_x_pos,
  input  logic       hit_taken,
  input  logic [4:0] load_frame,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic [3:0] state,
  output logic [1:0] frame_state,
  output logic [4:0] frameCounter
);

  localparam logic [10:0] LEFT_STEP  = (IS_P2 != 1'b0) ? 11'(FWD_SPEED)  : 11'(BACK_SPEED);
  localparam logic [10:0] RIGHT_STEP = (IS_P2 != 1'b0) ? 11'(BACK_SPEED) : 11'(FWD_SPEED);

  char_state_e  state_q, state_d;
  frame_state_e frame_state_q, frame_state_d;
  logic [4:0]   fc_q, fc_d;
  logic [4:0]   stun_len_q, stun_len_d;
  logic [9:0]   x_q, x_d;
  logic [9:0]   y_q;

  logic btn_left_s, btn_right_s, btn_attack_s;
  logic fwd_s, back_s;

`ifdef CHAR_CPU_EN
  logic [15:0] lfsr_s;
  logic [11:0] lfsr_unused;

  char_cpu_lfsr u_cpu_lfsr (
    .clk  (clk),
    .rst  (rst),
    .step (frame_en),
    .lfsr (lfsr_s)
  );

  assign lfsr_unused = lfsr_s[15:4];

  // CPU mode replaces the player's buttons with pseudo-random presses
  always_comb begin
    if (cpu_mode) begin
      btn_attack_s = lfsr_s[0] & lfsr_s[1];
      btn_left_s   = lfsr_s[2] & ~lfsr_s[3];
      btn_right_s  = lfsr_s[3] & ~lfsr_s[2];
    end else begin
      btn_attack_s = btn_attack;
      btn_left_s   = btn_left;
      btn_right_s  = btn_right;
    end
  end
`else
  logic cpu_mode_unused;

  assign cpu_mode_unused = cpu_mode;
  assign btn_attack_s    = btn_attack;
  assign btn_left_s      = btn_left;
  assign btn_right_s     = btn_right;
`endif

  assign fwd_s  = (IS_P2 != 1'b0) ? btn_left_s  : btn_right_s;
  assign back_s = (IS_P2 != 1'b0) ? btn_right_s : btn_left_s;

  logic [10:0] x_ext_s, opp_ext_s, left_x_s, right_x_s;
  logic        left_ok_s, right_ok_s, block_s;

  // Candidate positions in 11 bits so a left step below X_MIN is caught before it wraps
  always_comb begin
    x_ext_s    = {1'b0, x_q};
    opp_ext_s  = {1'b0, opp_x_pos};
    left_x_s   = x_ext_s - LEFT_STEP;
    right_x_s  = x_ext_s + RIGHT_STEP;
    left_ok_s  = (x_ext_s >= ({1'b0, X_MIN} + LEFT_STEP)) &&
                 (abs_diff(left_x_s, opp_ext_s) >= {1'b0, CHAR_W});
    right_ok_s = (right_x_s <= {1'b0, X_MAX}) &&
                 (abs_diff(right_x_s, opp_ext_s) >= {1'b0, CHAR_W});
    block_s    = back_s && ((state_q == ST_IDLE) || (state_q == ST_LEFT) || (state_q == ST_RIGHT));
  end

  // Next-state, frame_state, stun length and position for one game frame
  always_comb begin
    state_d       = state_q;
    frame_state_d = frame_state_q;
    fc_d          = fc_q;
    stun_len_d    = stun_len_q;
    x_d           = x_q;
    if (frame_en) begin
      frame_state_d = FS_NOHIT;
      if (hit_taken && (state_q != ST_STUN)) begin
        state_d       = ST_STUN;
        frame_state_d = block_s ? FS_BLOCKSTUN : FS_HITSTUN;
      end else begin
        case (state_q)
          ST_IDLE, ST_LEFT, ST_RIGHT: begin
            if (!input_active) begin
              state_d = ST_IDLE;
            end else if (btn_attack_s && fwd_s) begin
              state_d = ST_DIR_START;
            end else if (btn_attack_s) begin
              state_d = ST_ATK_START;
            end else if (btn_left_s ^ btn_right_s) begin
              state_d = btn_left_s ? ST_LEFT : ST_RIGHT;
            end else begin
              state_d = ST_IDLE;
            end
          end
          ST_ATK_START:    state_d = phase_done(fc_q, ATK_START_LEN)    ? ST_ATK_ACTIVE   : state_q;
          ST_ATK_ACTIVE:   state_d = phase_done(fc_q, ATK_ACTIVE_LEN)   ? ST_ATK_RECOVERY : state_q;
          ST_ATK_RECOVERY: state_d = phase_done(fc_q, ATK_RECOVERY_LEN) ? ST_IDLE         : state_q;
          ST_DIR_START:    state_d = phase_done(fc_q, DIR_START_LEN)    ? ST_DIR_ACTIVE   : state_q;
          ST_DIR_ACTIVE:   state_d = phase_done(fc_q, DIR_ACTIVE_LEN)   ? ST_DIR_RECOVERY : state_q;
          ST_DIR_RECOVERY: state_d = phase_done(fc_q, DIR_RECOVERY_LEN) ? ST_IDLE         : state_q;
          ST_STUN: begin
            // stun_len is latched at frameCounter 1; counter 0 never exits
            if (fc_q == 5'd1) begin
              stun_len_d = stun_len_of(load_frame);
            end else begin
              stun_len_d = stun_len_q;
            end
            if ((fc_q != 5'd0) && (fc_q >= stun_len_d)) begin
              state_d = ST_IDLE;
            end else begin
              state_d = state_q;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
      if ((state_d == ST_LEFT) && left_ok_s) begin
        x_d = left_x_s[9:0];
      end else if ((state_d == ST_RIGHT) && right_ok_s) begin
        x_d = right_x_s[9:0];
      end else begin
        x_d = x_q;
      end
      fc_d = (state_d != state_q) ? 5'd0 : sat_inc(fc_q);
    end else begin
      fc_d = fc_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      frame_state_q <= FS_NOHIT;
      fc_q          <= 5'd0;
      stun_len_q    <= 5'd0;
      x_q           <= X_START;
      y_q           <= Y_BASE;
    end else begin
      state_q       <= state_d;
      frame_state_q <= frame_state_d;
      fc_q          <= fc_d;
      stun_len_q    <= stun_len_d;
      x_q           <= x_d;
      y_q           <= y_q;
    end
  end

  assign x_pos        = x_q;
  assign y_pos        = y_q;
  assign state        = state_q;
  assign frame_state  = frame_state_q;
  assign frameCounter = fc_q;

endmodule

// File: tb/tb_char_controller.sv
// Directed self-checking bench for char_controller (player 1, default parameters).
module tb_char_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_en = 1'b0;
  logic       input_active = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_attack = 1'b0;
  logic       cpu_mode = 1'b0;
  logic [9:0] opp_x_pos = 10'd400;
  logic       hit_taken = 1'b0;
  logic [4:0] load_frame = 5'd17;
  logic [9:0] x_pos, y_pos;
  logic [3:0] state;
  logic [1:0] frame_state;
  logic [4:0] frameCounter;

  int checks = 0;
  int errors = 0;
  int seen_active = 0;

  char_controller dut (
    .clk          (clk),
    .rst          (rst),
    .frame_en     (frame_en),
    .input_active (input_active),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_attack   (btn_attack),
    .cpu_mode     (cpu_mode),
    .opp_x_pos    (opp_x_pos),
    .hit_taken    (hit_taken),
    .load_frame   (load_frame),
    .x_pos        (x_pos),
    .y_pos        (y_pos),
    .state        (state),
    .frame_state  (frame_state),
    .frameCounter (frameCounter)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    // reset
    rst = 1'b1; frame_en = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rst_state", state, 0);
    chk("rst_x", x_pos, 100);
    chk("rst_y", y_pos, 300);
    chk("rst_fs", frame_state, 0);
    chk("rst_fc", frameCounter, 0);

    // forward walk, 3 px/frame
    input_active = 1'b1; btn_right = 1'b1;
    step(10);
    chk("walk_x", x_pos, 130);
    chk("walk_state", state, 2);
    chk("walk_fc", frameCounter, 9);

    // frame_en low holds everything
    frame_en = 1'b0;
    step(1);
    chk("hold_x", x_pos, 130);
    chk("hold_fc", frameCounter, 9);
    frame_en = 1'b1;

    // opponent separation: 136 is exactly CHAR_W from 200, 139 is blocked
    opp_x_pos = 10'd200;
    step(4);
    chk("sep_x", x_pos, 136);
    chk("sep_state", state, 2);
    btn_right = 1'b0;
    step(1);
    chk("release_state", state, 0);
    chk("release_fc", frameCounter, 0);

    // left clamp at X_MIN, 2 px/frame backward
    rst = 1'b1; step(1); rst = 1'b0;
    opp_x_pos = 10'd400; btn_left = 1'b1;
    step(52);
    chk("clamp_x", x_pos, 0);
    chk("clamp_state", state, 1);
    btn_left = 1'b0;
    step(1);
    chk("clamp_idle", state, 0);

    // neutral attack: 5/2/16 frames
    btn_attack = 1'b1; step(1); btn_attack = 1'b0;
    chk("atk_enter", state, 3);
    step(4);
    chk("atk_start_last", state, 3);
    chk("atk_start_fc", frameCounter, 4);
    step(1);
    chk("atk_active", state, 4);
    step(1);
    chk("atk_active_last", state, 4);
    step(1);
    chk("atk_recovery", state, 5);
    step(15);
    chk("atk_recovery_last", state, 5);
    chk("atk_recovery_fc", frameCounter, 15);
    step(1);
    chk("atk_done", state, 0);

    // directional attack: 4/3/15 frames
    btn_attack = 1'b1; btn_right = 1'b1; step(1); btn_attack = 1'b0; btn_right = 1'b0;
    chk("dir_enter", state, 6);
    step(3);
    chk("dir_start_last", state, 6);
    step(1);
    chk("dir_active", state, 7);
    step(2);
    chk("dir_active_last", state, 7);
    step(1);
    chk("dir_recovery", state, 8);
    step(14);
    chk("dir_recovery_last", state, 8);
    step(1);
    chk("dir_done", state, 0);

    // hit during ATK_START -> HITSTUN, stun_len 17, second hit ignored
    load_frame = 5'd17;
    btn_attack = 1'b1; step(1); btn_attack = 1'b0;
    step(1);
    chk("pre_hit_state", state, 3);
    hit_taken = 1'b1; step(1); hit_taken = 1'b0;
    chk("hit_state", state, 9);
    chk("hit_fs", frame_state, 1);
    chk("hit_fc", frameCounter, 0);
    step(1);
    chk("hit_fs_cleared", frame_state, 0);
    chk("hit_fc1", frameCounter, 1);
    step(4);
    hit_taken = 1'b1; step(1); hit_taken = 1'b0;
    chk("rehit_state", state, 9);
    chk("rehit_fc", frameCounter, 6);
    chk("rehit_fs", frame_state, 0);
    step(11);
    chk("stun_last", state, 9);
    chk("stun_last_fc", frameCounter, 17);
    step(1);
    chk("stun_exit", state, 0);

    // block in IDLE with backward held; hit wins over the button; minimum stun length
    load_frame = 5'd0;
    btn_left = 1'b1; hit_taken = 1'b1; step(1); btn_left = 1'b0; hit_taken = 1'b0;
    chk("block_state", state, 9);
    chk("block_fs", frame_state, 2);
    step(2);
    chk("min_stun_last", state, 9);
    chk("min_stun_fc", frameCounter, 2);
    step(1);
    chk("min_stun_exit", state, 0);

    // input gating
    input_active = 1'b0; btn_attack = 1'b1;
    step(3);
    chk("gate_attack", state, 0);
    btn_attack = 1'b0; input_active = 1'b1; btn_right = 1'b1;
    step(1);
    chk("gate_walk", state, 2);
    chk("gate_walk_x", x_pos, 3);
    input_active = 1'b0;
    step(1);
    chk("gate_stop", state, 0);
    chk("gate_stop_x", x_pos, 3);
    btn_right = 1'b0; input_active = 1'b1;

    // reset mid-attack at ATK_ACTIVE frame 1
    btn_attack = 1'b1; step(1); btn_attack = 1'b0;
    step(6);
    chk("mid_pre_state", state, 4);
    chk("mid_pre_fc", frameCounter, 1);
    rst = 1'b1; step(1); rst = 1'b0;
    chk("mid_rst_state", state, 0);
    chk("mid_rst_x", x_pos, 100);
    chk("mid_rst_fc", frameCounter, 0);

    // CPU mode: pseudo-random activity only when the feature is built in
    cpu_mode = 1'b1;
    for (int i = 0; i < 64; i++) begin
      step(1);
      if (state != 4'd0) seen_active = 1;
    end
    cpu_mode = 1'b0;
`ifdef CHAR_CPU_EN
    chk("cpu_activity", seen_active, 1);
`else
    chk("cpu_ignored", seen_active, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
